forward_stall_ctrl: RTL and testbench

FORWARD_STALL_CTRL -- requirements
Module: forward_stall_ctrl

---
 rtl/forward_stall_ctrl.sv | 118 +++++++++++
 tb/tb_forward_stall_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/forward_stall_ctrl.sv
// Operand-forwarding select and ID stall control for an in-order pipeline.
// Tracks one outstanding multi-cycle mult/div result and counts stalled cycles.
module forward_stall_ctrl #(
  parameter int NSRC   = 2,
  parameter int AW     = 5,
  parameter int MD_LAT = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 id_valid,
  input  logic [NSRC*AW-1:0]   id_src,
  input  logic [NSRC-1:0]      id_src_used,
  input  logic                 id_is_md,
  input  logic                 exe_valid,
  input  logic                 exe_wen,
  input  logic                 exe_is_load,
  input  logic [AW-1:0]        exe_wdest,
  input  logic                 mem_valid,
  input  logic                 mem_wen,
  input  logic [AW-1:0]        mem_wdest,
  input  logic                 wb_valid,
  input  logic                 wb_wen,
  input  logic [AW-1:0]        wb_wdest,
  input  logic                 md_start,
  input  logic [AW-1:0]        md_wdest,
  output logic [2*NSRC-1:0]    fwd_sel,
  output logic                 id_stall,
  output logic                 md_busy,
  output logic [15:0]          stall_cnt
);

  localparam logic [0:0]    ST_IDLE  = 1'b0;
  localparam logic [0:0]    ST_BUSY  = 1'b1;
  localparam logic [3:0]    CNT_INIT = 4'(MD_LAT - 1);
  localparam logic [AW-1:0] REG_ZERO = '0;

  logic [0:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] md_dest_q, md_dest_d;
  logic [15:0]   stall_cnt_q, stall_cnt_d;

  logic [AW-1:0] src_a [NSRC];
  logic [NSRC-1:0] rd_a;
  logic exe_wr, mem_wr, wb_wr;
  logic load_use, md_raw, busy;

  // Register 0 is hardwired; writes to it never forward or hazard.
  assign exe_wr = exe_valid & exe_wen & (exe_wdest != REG_ZERO);
  assign mem_wr = mem_valid & mem_wen & (mem_wdest != REG_ZERO);
  assign wb_wr  = wb_valid  & wb_wen  & (wb_wdest  != REG_ZERO);

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    assign src_a[g] = id_src[g*AW +: AW];
    assign rd_a[g]  = id_src_used[g] & (src_a[g] != REG_ZERO);
  end

  // NOTE: every output of this block gets a default before the loop, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    fwd_sel  = '0;
    load_use = 1'b0;
    md_raw   = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (rd_a[i]) begin
        if (exe_wr && exe_wdest == src_a[i])      fwd_sel[2*i +: 2] = 2'd1;
        else if (mem_wr && mem_wdest == src_a[i]) fwd_sel[2*i +: 2] = 2'd2;
        else if (wb_wr && wb_wdest == src_a[i])   fwd_sel[2*i +: 2] = 2'd3;
        if (exe_wr && exe_is_load && exe_wdest == src_a[i]) load_use = 1'b1;
        if (md_dest_q == src_a[i])                          md_raw   = 1'b1;
      end
    end
  end

  // The mult/div terms are masked during reset so only load-use can stall.
  assign busy      = (state_q == ST_BUSY) & resetn;
  assign md_busy   = busy;
  assign id_stall  = id_valid & (load_use | (busy & (md_raw | id_is_md)));
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_dest_d = md_dest_q;
    case (state_q)
      ST_IDLE: begin
        if (md_start) begin
          state_d   = ST_BUSY;
          cnt_d     = CNT_INIT;
          md_dest_d = md_wdest;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    stall_cnt_d = stall_cnt_q;
    if (id_stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      md_dest_q   <= REG_ZERO;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      md_dest_q   <= md_dest_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_forward_stall_ctrl.sv
// Self-checking bench for forward_stall_ctrl: vector table for forwarding and
// load-use, hand sequences for mult/div tracking, reset abort and saturation.
module tb_forward_stall_ctrl;

  logic        clk;
  logic        resetn;
  logic        id_valid;
  logic [9:0]  id_src;
  logic [1:0]  id_src_used;
  logic        id_is_md;
  logic        exe_valid, exe_wen, exe_is_load;
  logic [4:0]  exe_wdest;
  logic        mem_valid, mem_wen;
  logic [4:0]  mem_wdest;
  logic        wb_valid, wb_wen;
  logic [4:0]  wb_wdest;
  logic        md_start;
  logic [4:0]  md_wdest;
  logic [3:0]  fwd_sel;
  logic        id_stall;
  logic        md_busy;
  logic [15:0] stall_cnt;

  forward_stall_ctrl #(.NSRC(2), .AW(5), .MD_LAT(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .id_valid   (id_valid),
    .id_src     (id_src),
    .id_src_used(id_src_used),
    .id_is_md   (id_is_md),
    .exe_valid  (exe_valid),
    .exe_wen    (exe_wen),
    .exe_is_load(exe_is_load),
    .exe_wdest  (exe_wdest),
    .mem_valid  (mem_valid),
    .mem_wen    (mem_wen),
    .mem_wdest  (mem_wdest),
    .wb_valid   (wb_valid),
    .wb_wen     (wb_wen),
    .wb_wdest   (wb_wdest),
    .md_start   (md_start),
    .md_wdest   (md_wdest),
    .fwd_sel    (fwd_sel),
    .id_stall   (id_stall),
    .md_busy    (md_busy),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       idv;
    logic [4:0] s0, s1;
    logic [1:0] used;
    logic [2:0] exe;   // {valid, wen, is_load}
    logic [4:0] exe_d;
    logic [1:0] mem;   // {valid, wen}
    logic [4:0] mem_d;
    logic [1:0] wb;    // {valid, wen}
    logic [4:0] wb_d;
    logic [3:0] fwd;
    logic       chk_fwd;
    logic       stall;
  } vec_t;

  typedef struct {
    string       name;
    logic [3:0]  fwd;
    logic        chk_fwd;
    logic        stall;
    logic        busy;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_err    = 0;
  logic [15:0] model_cnt;
  vec_t        vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    id_valid = 1'b0; id_src = '0; id_src_used = '0; id_is_md = 1'b0;
    exe_valid = 1'b0; exe_wen = 1'b0; exe_is_load = 1'b0; exe_wdest = '0;
    mem_valid = 1'b0; mem_wen = 1'b0; mem_wdest = '0;
    wb_valid = 1'b0; wb_wen = 1'b0; wb_wdest = '0;
    md_start = 1'b0; md_wdest = '0;
  endtask

  task automatic set_id(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] used, input logic is_md);
    id_valid = v; id_src = {s1, s0}; id_src_used = used; id_is_md = is_md;
  endtask

  // Expectation is queued as stimulus is applied, popped when outputs are sampled.
  task automatic step(input string name, input logic [3:0] fwd, input logic chk_fwd,
                      input logic stall, input logic busy);
    exp_t e;
    e.name = name; e.fwd = fwd; e.chk_fwd = chk_fwd;
    e.stall = stall; e.busy = busy; e.cnt = model_cnt;
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    if (e.chk_fwd) check({e.name, "/fwd_sel"}, 32'(fwd_sel), 32'(e.fwd));
    check({e.name, "/id_stall"},  32'(id_stall),  32'(e.stall));
    check({e.name, "/md_busy"},   32'(md_busy),   32'(e.busy));
    check({e.name, "/stall_cnt"}, 32'(stall_cnt), 32'(e.cnt));
    @(posedge clk);
    if (!resetn)                                  model_cnt = 16'd0;
    else if (e.stall && model_cnt != 16'hFFFF)    model_cnt = model_cnt + 16'd1;
    #1;
  endtask

  function automatic vec_t mkv(string name, logic idv, logic [4:0] s0, logic [4:0] s1,
                               logic [1:0] used, logic [2:0] exe, logic [4:0] exe_d,
                               logic [1:0] mem, logic [4:0] mem_d, logic [1:0] wb,
                               logic [4:0] wb_d, logic [3:0] fwd, logic chk_fwd,
                               logic stall);
    vec_t v;
    v.name = name; v.idv = idv; v.s0 = s0; v.s1 = s1; v.used = used;
    v.exe = exe; v.exe_d = exe_d; v.mem = mem; v.mem_d = mem_d;
    v.wb = wb; v.wb_d = wb_d; v.fwd = fwd; v.chk_fwd = chk_fwd; v.stall = stall;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //             name               idv s0 s1 used  exe    ed  mem   md  wb    wd  fwd      chk stall
    vecs[0]  = mkv("fwd_exe_over_mem", 1, 5, 0, 2'b01, 3'b110, 5, 2'b11, 5, 2'b00, 0, 4'b0001, 1, 0);
    vecs[1]  = mkv("fwd_mem",          1, 5, 0, 2'b01, 3'b000, 0, 2'b11, 5, 2'b00, 0, 4'b0010, 1, 0);
    vecs[2]  = mkv("fwd_wb_op1",       1, 0, 7, 2'b10, 3'b000, 0, 2'b00, 0, 2'b11, 7, 4'b1100, 1, 0);
    vecs[3]  = mkv("r0_all_stages",    1, 0, 0, 2'b11, 3'b111, 0, 2'b11, 0, 2'b11, 0, 4'b0000, 1, 0);
    vecs[4]  = mkv("unused_operand",   1, 9, 0, 2'b00, 3'b110, 9, 2'b00, 0, 2'b00, 0, 4'b0000, 1, 0);
    vecs[5]  = mkv("exe_not_valid",    1, 9, 0, 2'b01, 3'b010, 9, 2'b11, 9, 2'b00, 0, 4'b0010, 1, 0);
    vecs[6]  = mkv("exe_no_wen",       1, 9, 0, 2'b01, 3'b100, 9, 2'b00, 0, 2'b11, 9, 4'b0011, 1, 0);
    vecs[7]  = mkv("mem_over_wb",      1, 4, 0, 2'b01, 3'b000, 0, 2'b11, 4, 2'b11, 4, 4'b0010, 1, 0);
    vecs[8]  = mkv("load_in_mem",      1, 0, 4, 2'b10, 3'b000, 0, 2'b11, 4, 2'b00, 0, 4'b1000, 1, 0);
    vecs[9]  = mkv("load_no_id_valid", 0, 6, 0, 2'b01, 3'b111, 6, 2'b00, 0, 2'b00, 0, 4'b0001, 1, 0);
    vecs[10] = mkv("load_use",         1, 6, 0, 2'b01, 3'b111, 6, 2'b00, 0, 2'b00, 0, 4'b0000, 0, 1);
    vecs[11] = mkv("load_unused_op",   1, 6, 1, 2'b10, 3'b111, 6, 2'b00, 0, 2'b00, 0, 4'b0000, 1, 0);
    vecs[12] = mkv("split_operands",   1, 2, 1, 2'b11, 3'b110, 1, 2'b11, 2, 2'b00, 0, 4'b0110, 1, 0);
    vecs[13] = mkv("all_write_r3",     1, 3, 3, 2'b11, 3'b110, 3, 2'b11, 3, 2'b11, 3, 4'b0101, 1, 0);

    clear_inputs();
    resetn    = 1'b0;
    model_cnt = 16'd0;
    @(posedge clk); #1;

    // Reset state
    step("reset0", 4'b0000, 1, 0, 0);
    step("reset1", 4'b0000, 1, 0, 0);
    resetn = 1'b1;

    // Load-use stall, then the load forwards from MEM
    set_id(1, 0, 8, 2'b10, 0);
    exe_valid = 1; exe_wen = 1; exe_is_load = 1; exe_wdest = 8;
    step("lu_stall", 4'b0000, 0, 1, 0);
    exe_valid = 0; exe_wen = 0; exe_is_load = 0; exe_wdest = 0;
    mem_valid = 1; mem_wen = 1; mem_wdest = 8;
    step("lu_mem_fwd", 4'b1000, 1, 0, 0);

    // Vector table
    foreach (vecs[k]) begin
      clear_inputs();
      set_id(vecs[k].idv, vecs[k].s0, vecs[k].s1, vecs[k].used, 0);
      {exe_valid, exe_wen, exe_is_load} = vecs[k].exe;
      exe_wdest = vecs[k].exe_d;
      {mem_valid, mem_wen} = vecs[k].mem;
      mem_wdest = vecs[k].mem_d;
      {wb_valid, wb_wen} = vecs[k].wb;
      wb_wdest = vecs[k].wb_d;
      step(vecs[k].name, vecs[k].fwd, vecs[k].chk_fwd, vecs[k].stall, 0);
    end

    // Mult/div RAW: start to r3, read r3 every cycle
    clear_inputs();
    md_start = 1; md_wdest = 3;
    set_id(1, 3, 0, 2'b01, 0);
    step("md_raw_c0", 4'b0000, 1, 0, 0);
    md_start = 0;
    for (int c = 1; c <= 4; c++) step($sformatf("md_raw_c%0d", c), 4'b0000, 1, 1, 1);
    step("md_raw_c5", 4'b0000, 1, 0, 0);

    // Structural stall; a second start while busy is ignored
    clear_inputs();
    md_start = 1; md_wdest = 10;
    step("md_struct_c0", 4'b0000, 1, 0, 0);
    for (int c = 1; c <= 4; c++) begin
      md_start = (c == 2); md_wdest = 11;
      set_id(1, 1, 2, 2'b11, 1);
      step($sformatf("md_struct_c%0d", c), 4'b0000, 1, 1, 1);
    end
    md_start = 0;
    set_id(1, 11, 0, 2'b01, 1);
    step("md_struct_c5", 4'b0000, 1, 0, 0);

    // Mult/div to r0 is busy but never raises a RAW stall
    clear_inputs();
    md_start = 1; md_wdest = 0;
    step("md_r0_c0", 4'b0000, 1, 0, 0);
    md_start = 0;
    set_id(1, 0, 0, 2'b11, 0);
    for (int c = 1; c <= 4; c++) step($sformatf("md_r0_c%0d", c), 4'b0000, 1, 0, 1);
    step("md_r0_c5", 4'b0000, 1, 0, 0);

    // Reset in the middle of BUSY aborts tracking
    clear_inputs();
    md_start = 1; md_wdest = 7;
    step("md_rst_c0", 4'b0000, 1, 0, 0);
    md_start = 0;
    set_id(1, 7, 0, 2'b01, 0);
    step("md_rst_c1", 4'b0000, 1, 1, 1);
    resetn = 0;
    step("md_rst_c2", 4'b0000, 1, 0, 0);
    set_id(1, 7, 20, 2'b11, 0);
    exe_valid = 1; exe_wen = 1; exe_is_load = 1; exe_wdest = 20;
    step("rst_load_use", 4'b0000, 0, 1, 0);
    resetn = 1;
    exe_valid = 0; exe_wen = 0; exe_is_load = 0; exe_wdest = 0;
    set_id(1, 7, 0, 2'b01, 0);
    step("md_rst_c4", 4'b0000, 1, 0, 0);
    step("md_rst_c5", 4'b0000, 1, 0, 0);

    // Stall counter saturation
    clear_inputs();
    set_id(1, 8, 0, 2'b01, 0);
    exe_valid = 1; exe_wen = 1; exe_is_load = 1; exe_wdest = 8;
    repeat (65535) begin
      @(posedge clk);
      if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
    end
    #1;
    @(negedge clk);
    check("sat_reach/stall_cnt", 32'(stall_cnt), 32'(model_cnt));
    check("sat_reach/id_stall",  32'(id_stall),  32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("sat_hold/stall_cnt",  32'(stall_cnt), 32'h0000_FFFF);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
